// File: rtl/cc_mux101_scan_controller.sv
// Scan sequencer for the CC_MUX101 10:1 selector: walks enabled channels,
// holds each for a programmable dwell, strobes on the last dwell cycle and flags end of frame.
module cc_mux101_scan_controller #(
    parameter int SELECTWIDTH = 4,
    parameter int NUM_CH      = 10,
    parameter int DWELLWIDTH  = 16
) (
    input  logic                   CC_MUXSCAN_CLOCK_50,
    input  logic                   CC_MUXSCAN_RESET_InLow,
    input  logic                   CC_MUXSCAN_start_In,
    input  logic                   CC_MUXSCAN_continuous_In,
    input  logic [NUM_CH-1:0]      CC_MUXSCAN_mask_InBUS,
    input  logic [DWELLWIDTH-1:0]  CC_MUXSCAN_dwell_InBUS,
    output logic [SELECTWIDTH-1:0] CC_MUXSCAN_select_OutBUS,
    output logic                   CC_MUXSCAN_strobe_Out,
    output logic                   CC_MUXSCAN_busy_Out,
    output logic                   CC_MUXSCAN_frameDone_Out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } scanState_t;

    localparam logic [SELECTWIDTH-1:0] LAST_IDX = SELECTWIDTH'(NUM_CH - 1);

    scanState_t              state_r, nextState_s;
    logic [SELECTWIDTH-1:0]  index_r, nextIndex_s;
    logic [DWELLWIDTH-1:0]   dwellCnt_r, nextDwellCnt_s;
    logic [NUM_CH-1:0]       mask_r, nextMask_s;
    logic [DWELLWIDTH-1:0]   dwell_r, nextDwell_s;
    logic                    strobe_r, busy_r, frameDone_r;

    // Next-state, index, dwell counter and configuration latching.
    always_comb begin
        nextState_s    = state_r;
        nextIndex_s    = index_r;
        nextDwellCnt_s = dwellCnt_r;
        nextMask_s     = mask_r;
        nextDwell_s    = dwell_r;
        case (state_r)
            IDLE: begin
                nextIndex_s = {SELECTWIDTH{1'b0}};
                if (CC_MUXSCAN_start_In) begin
                    nextState_s = SEEK;
                    nextMask_s  = CC_MUXSCAN_mask_InBUS;
                    nextDwell_s = CC_MUXSCAN_dwell_InBUS;
                end else begin
                    nextState_s = IDLE;
                end
            end
            SEEK: begin
                if (mask_r[index_r]) begin
                    nextState_s    = DWELL;
                    nextDwellCnt_s = dwell_r;
                end else if (index_r == LAST_IDX) begin
                    nextState_s = DONE;
                end else begin
                    nextIndex_s = index_r + SELECTWIDTH'(1);
                end
            end
            DWELL: begin
                if (dwellCnt_r != {DWELLWIDTH{1'b0}}) begin
                    nextDwellCnt_s = dwellCnt_r - DWELLWIDTH'(1);
                end else if (index_r == LAST_IDX) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = SEEK;
                    nextIndex_s = index_r + SELECTWIDTH'(1);
                end
            end
            DONE: begin
                nextIndex_s = {SELECTWIDTH{1'b0}};
                if (CC_MUXSCAN_continuous_In) begin
                    nextState_s = SEEK;
                    nextMask_s  = CC_MUXSCAN_mask_InBUS;
                    nextDwell_s = CC_MUXSCAN_dwell_InBUS;
                end else begin
                    nextState_s = IDLE;
                end
            end
            default: begin
                nextState_s = IDLE;
                nextIndex_s = {SELECTWIDTH{1'b0}};
            end
        endcase
    end

    // State and configuration registers; outputs are computed from the next
    // state so they equal the decode of the current registers with no input path.
    always_ff @(posedge CC_MUXSCAN_CLOCK_50) begin
        if (!CC_MUXSCAN_RESET_InLow) begin
            state_r      <= IDLE;
            index_r      <= {SELECTWIDTH{1'b0}};
            dwellCnt_r   <= {DWELLWIDTH{1'b0}};
            mask_r       <= {NUM_CH{1'b0}};
            dwell_r      <= {DWELLWIDTH{1'b0}};
            strobe_r     <= 1'b0;
            busy_r       <= 1'b0;
            frameDone_r  <= 1'b0;
        end else begin
            state_r      <= nextState_s;
            index_r      <= nextIndex_s;
            dwellCnt_r   <= nextDwellCnt_s;
            mask_r       <= nextMask_s;
            dwell_r      <= nextDwell_s;
            strobe_r     <= (nextState_s == DWELL) && (nextDwellCnt_s == {DWELLWIDTH{1'b0}});
            busy_r       <= (nextState_s != IDLE);
            frameDone_r  <= (nextState_s == DONE);
        end
    end

    assign CC_MUXSCAN_select_OutBUS = index_r;
    assign CC_MUXSCAN_strobe_Out    = strobe_r;
    assign CC_MUXSCAN_busy_Out      = busy_r;
    assign CC_MUXSCAN_frameDone_Out = frameDone_r;

endmodule
